fifo_status_buffer: RTL and testbench

Synchronous data FIFO that sits directly upstream of the flow-control FSM. It buffers 8-bit words and produces the status flags the FSM consumes: empty/non-empty, almost-full, almost-empty and overflow. It also supplies the registered read word `data_Fifo`. Thresholds have power-up defaults and are reprogrammed by the same `init` strobe that starts the FSM.

---
 rtl/fifo_status_buffer_if.sv | 30 +++
 rtl/fifo_status_buffer.sv | 112 +++++++++++
 tb/tb_fifo_status_buffer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/fifo_status_buffer_if.sv
// Push/pop handshake and status bundle of the FIFO that feeds the flow-control FSM.
// The bench drives through the master modport; the FIFO uses the slave modport.
interface fifo_status_buffer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
);
  logic              push;
  logic [DATA_W-1:0] data_in;
  logic              pop;
  logic [DATA_W-1:0] data_Fifo;
  logic [ADDR_W:0]   count;
  logic              empty_Fifo;
  logic              no_empty_Fifo;
  logic              full_Fifo;
  logic              almost_full;
  logic              almost_empty;
  logic              Fifo_overflow;

  modport master (
    output push, data_in, pop,
    input  data_Fifo, count, empty_Fifo, no_empty_Fifo, full_Fifo,
    input  almost_full, almost_empty, Fifo_overflow
  );

  modport slave (
    input  push, data_in, pop,
    output data_Fifo, count, empty_Fifo, no_empty_Fifo, full_Fifo,
    output almost_full, almost_empty, Fifo_overflow
  );
endinterface

// File: rtl/fifo_status_buffer.sv
// Synchronous data FIFO with registered read word, programmable almost-full/almost-empty flags
// and overflow flag. Define FIFO_OVERFLOW_STICKY_EN for a sticky overflow flag (default: pulse).
module fifo_status_buffer #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned AF_DEFAULT = 6,
  parameter int unsigned AE_DEFAULT = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            init,
  input  logic [ADDR_W:0] umbral_af,
  input  logic [ADDR_W:0] umbral_ae,
  fifo_status_buffer_if.slave bus
);
  localparam int unsigned     DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DepthCnt  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AfDefault = (ADDR_W + 1)'(AF_DEFAULT);
  localparam logic [ADDR_W:0] AeDefault = (ADDR_W + 1)'(AE_DEFAULT);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   af_q, af_d;
  logic [ADDR_W:0]   ae_q, ae_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ovf_q, ovf_d;
  logic              empty, full, push_acc, pop_acc, drop, mem_we;

  assign empty    = (count_q == '0);
  assign full     = (count_q == DepthCnt);
  // A full FIFO still takes a write when a read frees the same slot in this cycle.
  assign push_acc = bus.push && (!full || bus.pop);
  assign pop_acc  = bus.pop && !empty;
  assign drop     = bus.push && full && !bus.pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    af_d     = af_q;
    ae_d     = ae_q;
    data_d   = data_q;
    ovf_d    = ovf_q;
    mem_we   = 1'b0;
    if (init) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      af_d     = umbral_af;
      ae_d     = umbral_ae;
      ovf_d    = 1'b0;
    end else begin
      if (push_acc) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (pop_acc) begin
        data_d   = mem_q[rd_ptr_q];
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end
      if (push_acc && !pop_acc) begin
        count_d = count_q + (ADDR_W + 1)'(1);
      end else if (pop_acc && !push_acc) begin
        count_d = count_q - (ADDR_W + 1)'(1);
      end
`ifdef FIFO_OVERFLOW_STICKY_EN
      ovf_d = ovf_q | drop;
`else
      ovf_d = drop;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      af_q     <= AfDefault;
      ae_q     <= AeDefault;
      data_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is never cleared; pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem_q[wr_ptr_q] <= bus.data_in;
    end
  end

  assign bus.data_Fifo     = data_q;
  assign bus.count         = count_q;
  assign bus.empty_Fifo    = empty;
  assign bus.no_empty_Fifo = !empty;
  assign bus.full_Fifo     = full;
  assign bus.almost_full   = (count_q >= af_q);
  assign bus.almost_empty  = (count_q <= ae_q);
  assign bus.Fifo_overflow = ovf_q;

endmodule

// File: tb/tb_fifo_status_buffer.sv
// Scoreboard bench for fifo_status_buffer: a queue model tracks contents and flags, and
// popped words are queued as expected read data and compared one cycle later.
module tb_fifo_status_buffer;
  logic       clk;
  logic       reset;
  logic       init;
  logic [3:0] umbral_af;
  logic [3:0] umbral_ae;

  fifo_status_buffer_if #(.DATA_W(8), .ADDR_W(3)) bus ();

  fifo_status_buffer #(
    .DATA_W    (8),
    .ADDR_W    (3),
    .AF_DEFAULT(6),
    .AE_DEFAULT(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .init     (init),
    .umbral_af(umbral_af),
    .umbral_ae(umbral_ae),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [7:0] mdl[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_data;
  int         mdl_af;
  int         mdl_ae;
  bit         exp_ovf;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock of stimulus; model is advanced from pre-edge state, outputs checked #1 after.
  task automatic step(input bit p, input logic [7:0] d, input bit q,
                      input bit ini, input bit rst);
    bit full_m, empty_m, pa, qa, drop;
    int cnt;
    bus.push  = p;
    bus.data_in = d;
    bus.pop   = q;
    init      = ini;
    reset     = rst;
    qa = 1'b0;
    if (rst) begin
      mdl.delete();
      exp_q.delete();
      mdl_af = 6;
      mdl_ae = 2;
      exp_ovf = 1'b0;
      exp_data = 8'h00;
    end else if (ini) begin
      mdl.delete();
      mdl_af = int'(umbral_af);
      mdl_ae = int'(umbral_ae);
      exp_ovf = 1'b0;
    end else begin
      full_m  = (mdl.size() == 8);
      empty_m = (mdl.size() == 0);
      pa   = p && (!full_m || q);
      qa   = q && !empty_m;
      drop = p && full_m && !q;
      if (qa) exp_q.push_back(mdl.pop_front());
      if (pa) mdl.push_back(d);
`ifdef FIFO_OVERFLOW_STICKY_EN
      exp_ovf = exp_ovf | drop;
`else
      exp_ovf = drop;
`endif
    end
    @(posedge clk);
    #1;
    if (qa && exp_q.size() > 0) exp_data = exp_q.pop_front();
    cnt = mdl.size();
    check_val("data_Fifo", 32'(bus.data_Fifo), 32'(exp_data));
    check_val("count", 32'(bus.count), 32'(cnt));
    check_val("empty_Fifo", 32'(bus.empty_Fifo), 32'(cnt == 0));
    check_val("no_empty_Fifo", 32'(bus.no_empty_Fifo), 32'(cnt != 0));
    check_val("full_Fifo", 32'(bus.full_Fifo), 32'(cnt == 8));
    check_val("almost_full", 32'(bus.almost_full), 32'(cnt >= mdl_af));
    check_val("almost_empty", 32'(bus.almost_empty), 32'(cnt <= mdl_ae));
    check_val("Fifo_overflow", 32'(bus.Fifo_overflow), 32'(exp_ovf));
  endtask

  initial begin
    bus.push    = 1'b0;
    bus.data_in = 8'h00;
    bus.pop     = 1'b0;
    init        = 1'b0;
    reset       = 1'b1;
    umbral_af   = 4'd0;
    umbral_ae   = 4'd0;
    mdl_af      = 6;
    mdl_ae      = 2;
    exp_ovf     = 1'b0;
    exp_data    = 8'h00;

    // Reset and idle.
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Fill 0x01..0x08, then two dropped pushes and idle.
    for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hAB, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Push+pop while full: oldest out, 0x55 read last.
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    // Pop on empty is rejected; then push+pop on empty.
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h66, 1'b1, 1'b0, 1'b0);

    // Reach 5 words, then init with new thresholds while a push is requested.
    for (int i = 0; i < 4; i++) step(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0, 1'b0);
    umbral_af = 4'd4;
    umbral_ae = 4'd1;
    step(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
    umbral_af = 4'd0;
    umbral_ae = 4'd0;
    for (int i = 0; i < 5; i++) step(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Degenerate thresholds: AF=0 and AE>=DEPTH force both flags high.
    umbral_af = 4'd0;
    umbral_ae = 4'd8;
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 8'h90 + 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h9F, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Pointer wrap at occupancy 3 with a reset mid-sequence.
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (i == 12) step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
      step(1'b1, 8'h10 + 8'(i), 1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    check_val("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
